// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART TX arbiter and its selector.
// Holds the arbiter FSM state encoding and the default byte width.
package uart_tx_arbiter_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } arb_state_e;

endpackage

// File: rtl/uart_rr_select.sv
// Round-robin selector: scans rr_ptr+1 .. rr_ptr (mod N_REQ) for the first
// set request. Ports: req, rr_ptr in; winner index and valid out.
module uart_rr_select #(
  parameter int N_REQ = 4,
  parameter int PW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    rr_ptr,
  output logic [PW-1:0]    winner,
  output logic             valid
);

  always_comb begin
    int idx;
    winner = '0;
    valid  = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      // explicit wrap so non-power-of-2 N_REQ works
      idx = int'(rr_ptr) + i;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte sources.
// Ports: clk, rst (async active-low), connection_status, req, req_data,
//   grant, done, tx_word, tx_start, tx_busy, err_timeout.
// Optional watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int DATA_W         = UART_DATA_W,
  parameter int TIMEOUT_CYCLES = 2048
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    connection_status,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        grant,
  output logic [N_REQ-1:0]        done,
  output logic [DATA_W-1:0]       tx_word,
  output logic                    tx_start,
  input  logic                    tx_busy,
  output logic                    err_timeout
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [PW-1:0] RR_RST = PW'(N_REQ - 1);

  arb_state_e state_q, state_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [N_REQ-1:0]  done_q, done_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic              start_q, start_d;
  logic              err_q, err_d;
  logic [PW-1:0]     owner_q, owner_d;
  logic [PW-1:0]     rr_q, rr_d;

  logic [PW-1:0] win;
  logic          win_vld;
  logic          tmo;
  logic          waiting;

  uart_rr_select #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_sel (
    .req    (req),
    .rr_ptr (rr_q),
    .winner (win),
    .valid  (win_vld)
  );

  assign waiting = (state_q == ST_WAIT_BUSY) ||
                   (state_q == ST_WAIT_DONE);

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 2) ?
                      $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  // START always leads into WAIT_BUSY, so clearing here
  // clears on entry to WAIT_BUSY.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_START) begin
      cnt_d = '0;
    end else if (waiting) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tmo = waiting &&
               (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = '0;
    done_d  = '0;
    word_d  = word_q;
    start_d = 1'b0;
    err_d   = 1'b0;
    owner_d = owner_q;
    rr_d    = rr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (connection_status && win_vld) begin
          word_d  = req_data[int'(win)*DATA_W +: DATA_W];
          owner_d = win;
          grant_d = N_REQ'(1) << win;
          state_d = ST_START;
        end
      end
      ST_START: begin
        // registered strobe lands one cycle after grant
        start_d = 1'b1;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (tmo) begin
          err_d   = 1'b1;
          rr_d    = owner_q;
          state_d = ST_IDLE;
        end else if (tx_busy) begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (tmo) begin
          err_d   = 1'b1;
          rr_d    = owner_q;
          state_d = ST_IDLE;
        end else if (!tx_busy) begin
          done_d  = N_REQ'(1) << owner_q;
          rr_d    = owner_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      done_q  <= '0;
      word_q  <= '0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
      owner_q <= '0;
      rr_q    <= RR_RST;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      word_q  <= word_d;
      start_q <= start_d;
      err_q   <= err_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
    end
  end

  assign grant       = grant_q;
  assign done        = done_q;
  assign tx_word     = word_q;
  assign tx_start    = start_q;
  assign err_timeout = err_q;

endmodule
